gelu_error_monitor: RTL and testbench

Hardware response checker for the 8-bit activation units (gelu_piecewise, gelu_lut, gelu_using_tanh). It consumes the stream of (x, y) pairs produced while an activation unit is swept over its full input range. Each y is compared against a golden GELU ROM, and the block accumulates error count, maximum absolute error and the x at which that maximum occurred. It sits downstream of the activation unit under test, so the FPGA self-test reports accuracy without a simulator.

---
 rtl/gelu_pkg.sv | 52 +++++
 rtl/gelu_golden_rom.sv | 26 ++
 rtl/gelu_error_monitor.sv | 131 +++++++++++++
 tb/tb_gelu_error_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gelu_pkg.sv
// Shared definitions for the GELU activation units and their response checker,
// including the golden-table generator used by both the LUT unit and the checker ROM.
package gelu_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_FRAC_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Golden GELU(x) in fixed point, rounded half away from zero and saturated.
    // Phi(x) = 1/2 + pdf(x) * sum x^(2n+1)/(1*3*...*(2n+1)); beyond |x| >= 6 the
    // result is within far less than half an LSB of x (positive) or 0 (negative).
    function automatic int gelu_golden(input int x_int, input int data_w, input int frac_w);
        real x, x2, term, sum, ex, ex_t, phi, v;
        int  r, hi, lo;
        x  = real'(x_int) / real'(1 << frac_w);
        hi = (1 << (data_w - 1)) - 1;
        lo = -(1 << (data_w - 1));
        if (x >= 6.0) begin
            r = x_int;
        end else if (x <= -6.0) begin
            r = 0;
        end else begin
            x2   = x * x;
            term = x;
            sum  = x;
            for (int n = 1; n < 100; n++) begin
                term = term * x2 / real'(2 * n + 1);
                sum  = sum + term;
            end
            ex   = 1.0;
            ex_t = 1.0;
            for (int k = 1; k < 100; k++) begin
                ex_t = ex_t * (x2 / 2.0) / real'(k);
                ex   = ex + ex_t;
            end
            phi = 0.5 + sum / (ex * 2.5066282746310002);
            v   = real'(x_int) * phi;
            if (v >= 0.0) r = $rtoi(v + 0.5);
            else          r = -$rtoi(0.5 - v);
        end
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

endpackage

// File: rtl/gelu_golden_rom.sv
// Synchronous-read golden GELU ROM, addressed by x as an unsigned offset (x + 2^(DATA_W-1)).
module gelu_golden_rom
    import gelu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic                     clk,
    input  logic [DATA_W-1:0]        addr,
    output logic signed [DATA_W-1:0] data
);

    localparam int DEPTH = 1 << DATA_W;

    logic signed [DATA_W-1:0] rom_tbl [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        localparam int GOLD = gelu_golden(i - DEPTH / 2, DATA_W, FRAC_W);
        assign rom_tbl[i] = DATA_W'(GOLD);
    end

    always_ff @(posedge clk) begin
        data <= rom_tbl[addr];
    end

endmodule

// File: rtl/gelu_error_monitor.sv
// Checks an activation unit's (x, y) sweep against the golden GELU ROM and
// accumulates error count, maximum |error| and the x where it first occurred.
module gelu_error_monitor
    import gelu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int TOL    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] y_in,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W:0]          err_count,
    output logic [DATA_W:0]          max_err,
    output logic signed [DATA_W-1:0] max_err_x,
    output logic                     seq_err
);

    localparam int              NSAMP    = 1 << DATA_W;
    localparam logic [DATA_W:0] LAST_CNT = (DATA_W + 1)'(NSAMP - 1);
    localparam logic [DATA_W:0] TOL_W    = (DATA_W + 1)'(TOL);

    state_t                   state, state_next;
    logic                     accept, clear, done_next;
    logic [DATA_W:0]          cnt;
    logic signed [DATA_W-1:0] exp_x;
    logic [DATA_W-1:0]        rom_addr;
    logic signed [DATA_W-1:0] golden;
    logic                     s1_valid, s2_valid;
    logic signed [DATA_W-1:0] s1_x, s1_y, s2_x;
    logic [DATA_W:0]          diff;
    logic [DATA_W:0]          s2_abs;

    // Adding 2^(DATA_W-1) to a DATA_W-bit two's-complement value flips its sign bit.
    assign rom_addr = {~x_in[DATA_W-1], x_in[DATA_W-2:0]};
    assign exp_x    = {~cnt[DATA_W-1], cnt[DATA_W-2:0]};
    assign diff     = {s1_y[DATA_W-1], s1_y} - {golden[DATA_W-1], golden};
    assign busy     = (state == RUN) || (state == DRAIN);

    gelu_golden_rom #(
        .DATA_W(DATA_W),
        .FRAC_W(FRAC_W)
    ) u_rom (
        .clk (clk),
        .addr(rom_addr),
        .data(golden)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        clear      = 1'b0;
        done_next  = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    clear      = 1'b1;
                end
            end
            RUN: begin
                if (in_valid) begin
                    accept = 1'b1;
                    if (cnt == LAST_CNT) state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!s1_valid && !s2_valid) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        s1_x   <= x_in;
        s1_y   <= y_in;
        s2_x   <= s1_x;
        s2_abs <= diff[DATA_W] ? (~diff + 1'b1) : diff;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            cnt       <= '0;
            seq_err   <= 1'b0;
            err_count <= '0;
            max_err   <= '0;
            max_err_x <= '0;
        end else begin
            done     <= done_next;
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (clear) begin
                cnt       <= '0;
                seq_err   <= 1'b0;
                err_count <= '0;
                max_err   <= '0;
                max_err_x <= '0;
            end else begin
                // The expected x always advances, so one bad x does not resync the check.
                if (accept) begin
                    cnt <= cnt + 1'b1;
                    if (x_in != exp_x) seq_err <= 1'b1;
                end
                if (s2_valid) begin
                    if (s2_abs > TOL_W) err_count <= err_count + 1'b1;
                    if (s2_abs > max_err) begin
                        max_err   <= s2_abs;
                        max_err_x <= s2_x;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_gelu_error_monitor.sv
// Self-checking bench for gelu_error_monitor: randomized sweeps against a numeric GELU reference.
module tb_gelu_error_monitor;

    localparam int W   = 8;
    localparam int N   = 256;
    localparam int TOL = 1;

    logic              clk = 1'b0;
    logic              reset, start, in_valid;
    logic signed [7:0] x_in, y_in;
    logic              busy, done, seq_err;
    logic [8:0]        err_count, max_err;
    logic signed [7:0] max_err_x;

    int checks = 0;
    int errors = 0;
    int gold[N];
    int xs[N];
    int ys[N];

    always #5 clk = ~clk;

    gelu_error_monitor #(
        .DATA_W(W),
        .FRAC_W(4),
        .TOL   (TOL)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .x_in     (x_in),
        .y_in     (y_in),
        .busy     (busy),
        .done     (done),
        .err_count(err_count),
        .max_err  (max_err),
        .max_err_x(max_err_x),
        .seq_err  (seq_err)
    );

    // Reference GELU: Phi by Simpson integration of the normal density.
    function automatic real pdf(input real t);
        return $exp(-t * t / 2.0) / 2.5066282746310002;
    endfunction

    function automatic real phi_cdf(input real x);
        real h, s;
        if (x == 0.0) return 0.5;
        h = x / 2000.0;
        s = pdf(0.0) + pdf(x);
        for (int k = 1; k < 2000; k++) s = s + ((k % 2 == 1) ? 4.0 : 2.0) * pdf(real'(k) * h);
        return 0.5 + s * h / 3.0;
    endfunction

    function automatic int ref_gold(input int xi);
        real v;
        int  r;
        v = real'(xi) * phi_cdf(real'(xi) / 16.0);
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic int clamp8(input int v);
        return (v > 127) ? 127 : ((v < -128) ? -128 : v);
    endfunction

    function automatic void make_ideal();
        for (int i = 0; i < N; i++) begin
            xs[i] = i - 128;
            ys[i] = gold[i];
        end
    endfunction

    function automatic void make_random(input int rate);
        make_ideal();
        for (int i = 0; i < N; i++)
            if ($urandom_range(0, rate - 1) == 0)
                ys[i] = clamp8(gold[i] + int'($urandom_range(0, 80)) - 40);
    endfunction

    function automatic void model(output int ec, output int me, output int mx, output bit se);
        int d;
        ec = 0; me = 0; mx = 0; se = 1'b0;
        for (int i = 0; i < N; i++) begin
            d = ys[i] - gold[xs[i] + 128];
            if (d < 0) d = -d;
            if (d > TOL) ec++;
            if (d > me) begin
                me = d;
                mx = xs[i];
            end
            if (xs[i] != i - 128) se = 1'b1;
        end
    endfunction

    // Called and returns at a negedge; sends `count` samples from xs/ys.
    task automatic drive_sweep(input bit gapped, input int stray_at, input int count, input bit started);
        int i;
        bit phase;
        i = 0;
        phase = 1'b0;
        if (!started) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        while (i < count) begin
            in_valid = !(gapped && phase);
            phase    = gapped ? !phase : 1'b0;
            x_in     = 8'(xs[i]);
            y_in     = 8'(ys[i]);
            start    = (i == stray_at);
            @(negedge clk);
            start = 1'b0;
            if (in_valid) i++;
        end
        in_valid = 1'b0;
    endtask

    // Negedges from the one after the last accept until done; -1 if it never comes.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; x_in = '0; y_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
        checks++; if (err_count !== '0)  begin errors++; $display("FAIL reset_err_count: got %0d, expected 0", err_count); end
        checks++; if (max_err !== '0)    begin errors++; $display("FAIL reset_max_err: got %0d, expected 0", max_err); end
        checks++; if (max_err_x !== '0)  begin errors++; $display("FAIL reset_max_err_x: got %0d, expected 0", max_err_x); end
        checks++; if (seq_err !== 1'b0)  begin errors++; $display("FAIL reset_seq_err: got %b, expected 0", seq_err); end
    endtask

    task automatic test_ideal_sweep();
        int ec, me, mx, lat;
        bit se;
        make_ideal();
        model(ec, me, mx, se);
        drive_sweep(1'b0, -1, N, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ideal_busy_drain: got %b, expected 1", busy); end
        wait_done(lat);
        checks++; if (lat !== 3)              begin errors++; $display("FAIL ideal_done_latency: got %0d, expected 3", lat); end
        checks++; if (err_count !== 9'(ec))   begin errors++; $display("FAIL ideal_err_count: got %0d, expected %0d", err_count, ec); end
        checks++; if (max_err !== 9'(me))     begin errors++; $display("FAIL ideal_max_err: got %0d, expected %0d", max_err, me); end
        checks++; if (seq_err !== se)         begin errors++; $display("FAIL ideal_seq_err: got %b, expected %b", seq_err, se); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL ideal_busy_done: got %b, expected 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0)          begin errors++; $display("FAIL ideal_done_pulse: got %b, expected 0", done); end
    endtask

    task automatic test_single_fault();
        int ec, me, mx, lat;
        bit se;
        make_ideal();
        ys[16 + 128] = 16;
        model(ec, me, mx, se);
        drive_sweep(1'b0, -1, N, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 3)              begin errors++; $display("FAIL fault_done_latency: got %0d, expected 3", lat); end
        checks++; if (err_count !== 9'(ec))   begin errors++; $display("FAIL fault_err_count: got %0d, expected %0d", err_count, ec); end
        checks++; if (max_err !== 9'(me))     begin errors++; $display("FAIL fault_max_err: got %0d, expected %0d", max_err, me); end
        checks++; if (max_err_x !== 8'(mx))   begin errors++; $display("FAIL fault_max_err_x: got %0d, expected %0d", max_err_x, mx); end
    endtask

    task automatic test_tolerance_edge();
        int ec, me, mx, lat;
        bit se;
        int yv[2];
        yv[0] = -2;
        yv[1] = -5;
        for (int k = 0; k < 2; k++) begin
            make_ideal();
            ys[-16 + 128] = yv[k];
            model(ec, me, mx, se);
            drive_sweep(1'b0, -1, N, 1'b0);
            wait_done(lat);
            checks++; if (err_count !== 9'(ec)) begin errors++; $display("FAIL tol_err_count[y=%0d]: got %0d, expected %0d", yv[k], err_count, ec); end
            checks++; if (max_err !== 9'(me))   begin errors++; $display("FAIL tol_max_err[y=%0d]: got %0d, expected %0d", yv[k], max_err, me); end
            checks++; if (max_err_x !== 8'(mx)) begin errors++; $display("FAIL tol_max_err_x[y=%0d]: got %0d, expected %0d", yv[k], max_err_x, mx); end
        end
    endtask

    task automatic test_seq_break();
        int ec, me, mx, lat;
        bit se;
        make_random(16);
        xs[128] = 1;
        ys[128] = clamp8(gold[129] + int'($urandom_range(0, 6)) - 3);
        model(ec, me, mx, se);
        drive_sweep(1'b0, -1, N, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 3)             begin errors++; $display("FAIL seq_done_latency: got %0d, expected 3", lat); end
        checks++; if (seq_err !== se)        begin errors++; $display("FAIL seq_err_flag: got %b, expected %b", seq_err, se); end
        checks++; if (err_count !== 9'(ec))  begin errors++; $display("FAIL seq_err_count: got %0d, expected %0d", err_count, ec); end
        checks++; if (max_err !== 9'(me))    begin errors++; $display("FAIL seq_max_err: got %0d, expected %0d", max_err, me); end
    endtask

    task automatic test_gapped_stray_start();
        int ec, me, mx, lat;
        bit se;
        make_random(8);
        model(ec, me, mx, se);
        drive_sweep(1'b1, 100, N, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 3)             begin errors++; $display("FAIL gap_done_latency: got %0d, expected 3", lat); end
        checks++; if (err_count !== 9'(ec))  begin errors++; $display("FAIL gap_err_count: got %0d, expected %0d", err_count, ec); end
        checks++; if (max_err !== 9'(me))    begin errors++; $display("FAIL gap_max_err: got %0d, expected %0d", max_err, me); end
        checks++; if (max_err_x !== 8'(mx))  begin errors++; $display("FAIL gap_max_err_x: got %0d, expected %0d", max_err_x, mx); end
    endtask

    task automatic test_random_sweeps();
        int ec, me, mx, lat;
        bit se;
        for (int r = 0; r < 3; r++) begin
            make_random(4 + 4 * r);
            model(ec, me, mx, se);
            drive_sweep(1'b0, -1, N, 1'b0);
            wait_done(lat);
            checks++; if (err_count !== 9'(ec)) begin errors++; $display("FAIL rand%0d_err_count: got %0d, expected %0d", r, err_count, ec); end
            checks++; if (max_err !== 9'(me))   begin errors++; $display("FAIL rand%0d_max_err: got %0d, expected %0d", r, max_err, me); end
            checks++; if (max_err_x !== 8'(mx)) begin errors++; $display("FAIL rand%0d_max_err_x: got %0d, expected %0d", r, max_err_x, mx); end
        end
    endtask

    task automatic test_back_to_back();
        int ec, me, mx, lat;
        bit se;
        make_random(4);
        drive_sweep(1'b0, -1, N, 1'b0);
        wait_done(lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1)        begin errors++; $display("FAIL b2b_start_on_done: got busy %b, expected 1", busy); end
        checks++; if (err_count !== '0)     begin errors++; $display("FAIL b2b_cleared: got %0d, expected 0", err_count); end
        make_random(32);
        model(ec, me, mx, se);
        drive_sweep(1'b0, -1, N, 1'b1);
        wait_done(lat);
        checks++; if (lat !== 3)            begin errors++; $display("FAIL b2b_done_latency: got %0d, expected 3", lat); end
        checks++; if (err_count !== 9'(ec)) begin errors++; $display("FAIL b2b_err_count: got %0d, expected %0d", err_count, ec); end
        checks++; if (max_err !== 9'(me))   begin errors++; $display("FAIL b2b_max_err: got %0d, expected %0d", max_err, me); end
        checks++; if (max_err_x !== 8'(mx)) begin errors++; $display("FAIL b2b_max_err_x: got %0d, expected %0d", max_err_x, mx); end
    endtask

    task automatic test_ignore_outside_run();
        int ec, me, mx;
        bit se;
        model(ec, me, mx, se);
        repeat (6) begin
            in_valid = 1'b1;
            x_in     = 8'($urandom_range(0, 255));
            y_in     = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (err_count !== 9'(ec)) begin errors++; $display("FAIL idle_err_count: got %0d, expected %0d", err_count, ec); end
        checks++; if (max_err !== 9'(me))   begin errors++; $display("FAIL idle_max_err: got %0d, expected %0d", max_err, me); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL idle_busy: got %b, expected 0", busy); end
    endtask

    task automatic test_reset_mid_sweep();
        int ec, me, mx, lat;
        bit se;
        make_random(2);
        drive_sweep(1'b0, -1, 100, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        checks++; if (err_count !== '0)  begin errors++; $display("FAIL midrst_err_count: got %0d, expected 0", err_count); end
        checks++; if (max_err !== '0)    begin errors++; $display("FAIL midrst_max_err: got %0d, expected 0", max_err); end
        checks++; if (max_err_x !== '0)  begin errors++; $display("FAIL midrst_max_err_x: got %0d, expected 0", max_err_x); end
        repeat (3) @(negedge clk);
        checks++; if (max_err !== '0)    begin errors++; $display("FAIL midrst_inflight_max_err: got %0d, expected 0", max_err); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL midrst_done: got %b, expected 0", done); end
        make_random(6);
        model(ec, me, mx, se);
        drive_sweep(1'b0, -1, N, 1'b0);
        wait_done(lat);
        checks++; if (lat !== 3)            begin errors++; $display("FAIL midrst_done_latency: got %0d, expected 3", lat); end
        checks++; if (err_count !== 9'(ec)) begin errors++; $display("FAIL midrst_fresh_err_count: got %0d, expected %0d", err_count, ec); end
        checks++; if (max_err !== 9'(me))   begin errors++; $display("FAIL midrst_fresh_max_err: got %0d, expected %0d", max_err, me); end
        checks++; if (max_err_x !== 8'(mx)) begin errors++; $display("FAIL midrst_fresh_max_err_x: got %0d, expected %0d", max_err_x, mx); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) gold[i] = ref_gold(i - 128);
        test_reset();
        test_ideal_sweep();
        test_single_fault();
        test_tolerance_edge();
        test_seq_break();
        test_gapped_stray_start();
        test_random_sweeps();
        test_back_to_back();
        test_ignore_outside_run();
        test_reset_mid_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
